if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch producer that drives the IF/ID pipeline register. It holds the PC and issues word requests to instruction memory over a req/ack handshake. It presents each fetched instruction with its PC+4 to the IF/ID register, honours stall, and redirects on a taken branch. Whenever no valid instruction is available it emits all-zero bubbles (NOP, PC 0).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
stall  in  1  hazard stall; the output slot is not consumed while high.
branch_taken  in  1  redirect pulse, same cycle as IF/ID Flush.
branch_target  in  32  redirect address; bits [1:0] are ignored and forced to 00.
imem_req  out  1  instruction-memory request.
imem_addr  out  32  word address of the request.
imem_ack  in  1  read data is valid this cycle; completes the request.
imem_rdata  in  32  instruction word.
Instruction_out  out  32  to IF/ID Instruction_in; 0 when invalid.
PC_out  out  32  to IF/ID PC_in; fetch address + 4; 0 when invalid.
valid_out  out  1  output slot holds a real instruction.

Behaviour:
- Registers:
  - pc (next fetch address).
  - Output slot: Instruction_out, PC_out, valid_out.
  - One-entry skid: skid_instr, skid_pc.
  - state: FETCH, SKID, DRAIN.
- Async reset, takes effect immediately:
  - pc = RESET_PC.
  - state = FETCH.
  - All outputs and skid entries = 0.
  - imem_req = 0 while rst is high.
- imem_req = (state==FETCH or DRAIN) && !rst.
- imem_addr = pc.
- Request rule: once imem_req is asserted, it and imem_addr stay stable until the cycle with imem_ack. An ack in the same cycle as req is legal (zero wait).
- imem_ack outside FETCH/DRAIN is ignored.
- Slot accepts a load when (!valid_out || !stall).
- Slot consumption: a valid slot with !stall and no new load clears to valid_out=0, Instruction_out=0, PC_out=0.
- FETCH, on ack, no branch:
  - pc <= pc+4, wrapping mod 2^32.
  - If the slot accepts: slot <= {imem_rdata, pc+4, 1}; stay FETCH. Throughput is 1 instruction/cycle with zero-wait memory.
  - Else: skid <= {imem_rdata, pc+4}; go to SKID.
- FETCH, no ack: hold pc and request; the slot may still drain.
- SKID:
  - imem_req = 0.
  - When !stall: slot <= {skid_instr, skid_pc, 1}; go to FETCH.
  - Otherwise hold everything.
- DRAIN:
  - The wrong-path request is still outstanding, so imem_req stays high with imem_addr = the old address.
  - The old address is held in a separate register; pc already holds the target.
  - On ack: discard rdata; go to FETCH; the next request is to pc.
- branch_taken has highest priority and overrides stall and ack:
  - pc <= {branch_target[31:2], 2'b00}.
  - Slot cleared to zeros / invalid; skid dropped.
  - From FETCH with ack this cycle: rdata discarded; go to FETCH.
  - From FETCH without ack: go to DRAIN.
  - From SKID: go to FETCH.
  - From DRAIN: stay DRAIN; pc takes the newest target; the outstanding address is unchanged.
- Latency: ack at edge N puts the instruction on Instruction_out after edge N; the IF/ID register captures it at edge N+1 if !stall.
- No instruction is ever duplicated or lost across stall/skid transitions.

Decomposition:
- Shared package (mips_pkg):
  - Fetch state encoding (FETCH, SKID, DRAIN).
  - NOP_INSTR = 32'h0.
  - PC_STEP = 4.
  - Default RESET_PC.
- One natural sub-module: if_skid_buffer, holding the output slot plus skid entry with accept/consume logic. The top level keeps pc, state and the memory handshake.

Test Plan:
1. Reset released, imem_ack tied high, mem[a] = a | 32'hA000_0000 → imem_addr sequence 0,4,8; outputs (A000_0000, 4), (A000_0004, 8), … one per cycle; valid_out=0 and outputs 0 during reset.
2. ack delayed 3 cycles on address 0x8 → imem_addr stays 0x8 with req high for 3 cycles; valid_out=0 after the prior slot is consumed; the word at 0x8 is delivered with PC_out=0xC.
3. stall high 3 cycles while an ack arrives with the slot full → state SKID, req low, outputs unchanged; on stall release, the skid word appears next cycle and req resumes at the following address; no loss or duplication.
4. branch_taken with target 0x43 while a request to 0x10 is outstanding (no ack) → DRAIN: addr stays 0x10 until ack, that data is discarded, next request is 0x40, valid_out=0 until the 0x40 word returns with PC_out=0x44.
5. branch_taken, stall=1 and ack all in the same cycle → slot cleared to 0, nothing enters skid, pc=target, next cycle req to the target.
6. rst asserted asynchronously mid-SKID (between clock edges) → outputs drop to 0 immediately and req deasserts; after release, the first request is to RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front-end: fetch FSM states and
// architectural constants.
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        SKID  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_skid_buffer.sv
// Output slot feeding the IF/ID register plus a one-entry skid that catches
// a word returned while the slot is stalled.
module if_skid_buffer
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        stall,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_instr,
    input  logic [31:0] fetch_pc,
    input  logic        skid_release,
    output logic        accept,
    output logic [31:0] slot_instr,
    output logic [31:0] slot_pc,
    output logic        slot_valid
);

    logic [31:0] r_slot_instr;
    logic [31:0] r_slot_pc;
    logic        r_slot_valid;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;

    assign accept     = !r_slot_valid || !stall;
    assign slot_instr = r_slot_instr;
    assign slot_pc    = r_slot_pc;
    assign slot_valid = r_slot_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_instr <= NOP_INSTR;
            r_slot_pc    <= '0;
            r_slot_valid <= 1'b0;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc    <= '0;
        end else if (flush) begin
            r_slot_instr <= NOP_INSTR;
            r_slot_pc    <= '0;
            r_slot_valid <= 1'b0;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc    <= '0;
        end else if (fetch_valid && accept) begin
            r_slot_instr <= fetch_instr;
            r_slot_pc    <= fetch_pc;
            r_slot_valid <= 1'b1;
        end else if (fetch_valid) begin
            // Slot is full and stalled: park the word so it is not lost.
            r_skid_instr <= fetch_instr;
            r_skid_pc    <= fetch_pc;
        end else if (skid_release) begin
            r_slot_instr <= r_skid_instr;
            r_slot_pc    <= r_skid_pc;
            r_slot_valid <= 1'b1;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc    <= '0;
        end else if (r_slot_valid && !stall) begin
            r_slot_instr <= NOP_INSTR;
            r_slot_pc    <= '0;
            r_slot_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch producer: owns the PC, the imem req/ack handshake and
// branch redirection, and feeds the IF/ID register through if_skid_buffer.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = mips_pkg::DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction_out,
    output logic [31:0] PC_out,
    output logic        valid_out
);
    import mips_pkg::*;

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic [31:0]  r_drain_addr;
    logic [31:0]  w_drain_next;

    logic         w_req;
    logic         w_ack;
    logic         w_accept;
    logic         w_fetch_valid;
    logic         w_skid_release;
    logic [31:0]  w_target;
    logic [31:0]  w_pc_inc;

    assign w_req     = ((r_state == FETCH) || (r_state == DRAIN)) && !rst;
    assign w_ack     = imem_ack && w_req;
    assign w_target  = {branch_target[31:2], 2'b00};
    assign w_pc_inc  = r_pc + PC_STEP;
    assign imem_req  = w_req;
    assign imem_addr = (r_state == DRAIN) ? r_drain_addr : r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_drain_addr <= '0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_drain_addr <= w_drain_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_drain_next   = r_drain_addr;
        w_fetch_valid  = 1'b0;
        w_skid_release = 1'b0;
        case (r_state)
            FETCH: begin
                if (branch_taken) begin
                    w_pc_next = w_target;
                    // An unanswered request must still be completed before
                    // fetching from the new target.
                    if (!w_ack) begin
                        w_state_next = DRAIN;
                        w_drain_next = r_pc;
                    end
                end else if (w_ack) begin
                    w_pc_next     = w_pc_inc;
                    w_fetch_valid = 1'b1;
                    if (!w_accept) w_state_next = SKID;
                end
            end
            SKID: begin
                if (branch_taken) begin
                    w_pc_next    = w_target;
                    w_state_next = FETCH;
                end else if (!stall) begin
                    w_skid_release = 1'b1;
                    w_state_next   = FETCH;
                end
            end
            DRAIN: begin
                if (branch_taken) begin
                    w_pc_next = w_target;
                end else if (w_ack) begin
                    w_state_next = FETCH;
                end
            end
            default: w_state_next = FETCH;
        endcase
    end

    if_skid_buffer u_skid (
        .clk          (clk),
        .rst          (rst),
        .flush        (branch_taken),
        .stall        (stall),
        .fetch_valid  (w_fetch_valid),
        .fetch_instr  (imem_rdata),
        .fetch_pc     (w_pc_inc),
        .skid_release (w_skid_release),
        .accept       (w_accept),
        .slot_instr   (Instruction_out),
        .slot_pc      (PC_out),
        .slot_valid   (valid_out)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a queue-based fetch model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction_out;
    logic [31:0] PC_out;
    logic        valid_out;
    logic        ack_en;

    int errors = 0;
    int checks = 0;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .Instruction_out (Instruction_out),
        .PC_out          (PC_out),
        .valid_out       (valid_out)
    );

    // Memory: zero-wait when enabled, word content derived from its address.
    assign imem_ack   = ack_en && imem_req;
    assign imem_rdata = imem_addr | 32'hA000_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: words fetched but not yet taken by IF/ID (at most slot + skid),
    // next fetch address, and a pending wrong-path request to throw away.
    logic [31:0] q_instr[$];
    logic [31:0] q_pc[$];
    logic [31:0] m_pc;
    logic [31:0] m_old;
    bit          m_discard;

    task automatic model_reset();
        q_instr.delete();
        q_pc.delete();
        m_pc      = 32'h0;
        m_old     = 32'h0;
        m_discard = 1'b0;
    endtask

    function automatic bit m_req();
        return !rst && (q_instr.size() < 2);
    endfunction

    task automatic model_step();
        bit          req;
        bit          ack;
        logic [31:0] addr;
        if (rst) begin
            model_reset();
            return;
        end
        req  = m_req();
        addr = m_discard ? m_old : m_pc;
        ack  = ack_en && req;
        if (branch_taken) begin
            if (!m_discard && req && !ack) begin
                m_discard = 1'b1;
                m_old     = m_pc;
            end
            q_instr.delete();
            q_pc.delete();
            m_pc = branch_target & 32'hFFFF_FFFC;
        end else begin
            if (q_instr.size() > 0 && !stall) begin
                void'(q_instr.pop_front());
                void'(q_pc.pop_front());
            end
            if (ack) begin
                if (m_discard) begin
                    m_discard = 1'b0;
                end else begin
                    q_instr.push_back(addr | 32'hA000_0000);
                    q_pc.push_back(addr + 32'd4);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        bit exp_req;
        exp_req = m_req();
        check32("req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) check32("addr", imem_addr, m_discard ? m_old : m_pc);
        check32("valid", {31'b0, valid_out}, {31'b0, q_instr.size() > 0});
        check32("instr", Instruction_out, q_instr.size() > 0 ? q_instr[0] : 32'h0);
        check32("pc_out", PC_out, q_pc.size() > 0 ? q_pc[0] : 32'h0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input bit s, input bit a, input bit b, input logic [31:0] t);
        stall         = s;
        ack_en        = a;
        branch_taken  = b;
        branch_target = t;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1, 0, 32'h0);
        model_reset();
        cycle();
        check32("rst_valid", {31'b0, valid_out}, 32'h0);
        check32("rst_instr", Instruction_out, 32'h0);
        check32("rst_req", {31'b0, imem_req}, 32'h0);
        cycle();
        rst = 1'b0;

        // Zero-wait streaming from RESET_PC.
        cycle();
        check32("s1_instr0", Instruction_out, 32'hA000_0000);
        check32("s1_pc0", PC_out, 32'h4);
        cycle();
        check32("s1_instr1", Instruction_out, 32'hA000_0004);
        check32("s1_pc1", PC_out, 32'h8);
        check32("s1_addr", imem_addr, 32'h8);

        // Ack held off for three cycles on 0x8.
        drive(0, 0, 0, 32'h0);
        cycle();
        check32("s2_bubble", {31'b0, valid_out}, 32'h0);
        cycle();
        cycle();
        check32("s2_addr_hold", imem_addr, 32'h8);
        drive(0, 1, 0, 32'h0);
        cycle();
        check32("s2_instr", Instruction_out, 32'hA000_0008);
        check32("s2_pc", PC_out, 32'hC);

        // Stall with a full slot while an ack lands -> skid.
        drive(1, 1, 0, 32'h0);
        cycle();
        check32("s3_req_low", {31'b0, imem_req}, 32'h0);
        check32("s3_hold", Instruction_out, 32'hA000_0008);
        cycle();
        cycle();
        drive(0, 1, 0, 32'h0);
        cycle();
        check32("s3_skid_out", Instruction_out, 32'hA000_000C);
        check32("s3_skid_pc", PC_out, 32'h10);
        check32("s3_next_addr", imem_addr, 32'h10);

        // Branch to 0x43 with the request to 0x10 still unanswered.
        drive(0, 0, 0, 32'h0);
        cycle();
        drive(0, 0, 1, 32'h43);
        cycle();
        check32("s4_drain_addr", imem_addr, 32'h10);
        drive(0, 0, 0, 32'h0);
        cycle();
        drive(0, 1, 0, 32'h0);
        cycle();
        check32("s4_target_addr", imem_addr, 32'h40);
        check32("s4_discarded", {31'b0, valid_out}, 32'h0);
        cycle();
        check32("s4_instr", Instruction_out, 32'hA000_0040);
        check32("s4_pc", PC_out, 32'h44);

        // Branch, stall and ack in the same cycle.
        drive(1, 1, 1, 32'h80);
        cycle();
        check32("s5_cleared", Instruction_out, 32'h0);
        check32("s5_valid", {31'b0, valid_out}, 32'h0);
        check32("s5_addr", imem_addr, 32'h80);
        drive(0, 1, 0, 32'h0);
        cycle();
        check32("s5_pc", PC_out, 32'h84);

        // Re-redirect while draining keeps the outstanding address.
        drive(0, 0, 1, 32'h100);
        cycle();
        drive(0, 0, 1, 32'h206);
        cycle();
        check32("drain_keep", imem_addr, 32'h84);
        drive(0, 1, 0, 32'h0);
        cycle();
        check32("drain_newest", imem_addr, 32'h204);
        cycle();
        check32("drain_pc", PC_out, 32'h208);

        // PC wrap at the top of the address space.
        drive(0, 1, 1, 32'hFFFF_FFFF);
        cycle();
        drive(0, 1, 0, 32'h0);
        cycle();
        check32("wrap_instr", Instruction_out, 32'hFFFF_FFFC);
        check32("wrap_pc", PC_out, 32'h0);
        check32("wrap_valid", {31'b0, valid_out}, 32'h1);

        // Async reset in the middle of a skid episode.
        drive(1, 1, 0, 32'h0);
        cycle();
        check32("s6_skid_req", {31'b0, imem_req}, 32'h0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check32("s6_async_valid", {31'b0, valid_out}, 32'h0);
        check32("s6_async_instr", Instruction_out, 32'h0);
        check32("s6_async_pc", PC_out, 32'h0);
        check32("s6_async_req", {31'b0, imem_req}, 32'h0);
        drive(0, 1, 0, 32'h0);
        cycle();
        rst = 1'b0;
        #1;
        check32("s6_first_addr", imem_addr, 32'h0);
        check32("s6_first_req", {31'b0, imem_req}, 32'h1);
        cycle();
        check32("s6_instr", Instruction_out, 32'hA000_0000);
        check32("s6_pc", PC_out, 32'h4);
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
